// File: rtl/exa_vc_credit_scheduler.sv
// ============================================================================
// exa_vc_credit_scheduler: credit-gated strict-priority / round-robin packet
// scheduler for the shared ExaNet link.              Revision: 1.0
// ============================================================================
`default_nettype none

module exa_vc_credit_scheduler #(
  parameter  int PRIO_NUM     = 2,
  parameter  int VC_NUM       = 2,
  parameter  int CREDIT_W     = 4,
  parameter  int INIT_CREDITS = 8,
  localparam int Q            = PRIO_NUM * VC_NUM,
  localparam int SEL_W        = (Q > 1) ? $clog2(Q) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Q-1:0]          i_req,
  input  logic [Q-1:0]          i_credit_return,
  input  logic                  i_header_valid,
  input  logic                  i_header_ready,
  input  logic                  i_footer_valid,
  input  logic                  i_footer_ready,
  output logic [Q-1:0]          o_grant,
  output logic [SEL_W-1:0]      o_selected_vc,
  output logic                  o_busy,
  output logic [Q*CREDIT_W-1:0] o_credit_cnt,
  output logic                  o_credit_err,
  output logic                  o_proto_err
);

  localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int P_W  = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2
  } state_t;

  state_t          r_state;
  logic [VC_W-1:0] r_rr_ptr [PRIO_NUM];

  logic             w_hdr_hs;
  logic             w_ftr_hs;
  logic             w_any_elig;
  logic [Q-1:0]     w_elig;
  logic [Q-1:0]     w_dec;
  logic [Q-1:0]     w_pick_onehot;
  logic [SEL_W-1:0] w_pick_q;
  logic [P_W-1:0]   w_pick_prio;
  logic [VC_W-1:0]  w_next_ptr;

  assign w_hdr_hs   = i_header_valid & i_header_ready;
  assign w_ftr_hs   = i_footer_valid & i_footer_ready;
  assign w_any_elig = |w_elig;
  assign w_dec      = (r_state == S_HDR && w_hdr_hs) ? o_grant : '0;

  always_comb begin
    w_elig = '0;
    for (int q = 0; q < Q; q++)
      w_elig[q] = i_req[q] && (o_credit_cnt[q*CREDIT_W +: CREDIT_W] != '0);
  end

  // Levels are scanned low to high so the highest eligible level overwrites;
  // offsets are scanned far to near so the first vc at/after rr_ptr survives.
  always_comb begin
    logic lvl_found;
    int   lvl_vc;
    int   vc_idx;
    lvl_found   = 1'b0;
    lvl_vc      = 0;
    vc_idx      = 0;
    w_pick_q    = '0;
    w_pick_prio = '0;
    w_next_ptr  = '0;
    for (int p = 0; p < PRIO_NUM; p++) begin
      lvl_found = 1'b0;
      lvl_vc    = 0;
      for (int k = VC_NUM - 1; k >= 0; k--) begin
        vc_idx = (int'(r_rr_ptr[p]) + k) % VC_NUM;
        if (w_elig[p*VC_NUM + vc_idx]) begin
          lvl_found = 1'b1;
          lvl_vc    = vc_idx;
        end
      end
      if (lvl_found) begin
        w_pick_prio = P_W'(p);
        w_pick_q    = SEL_W'(p*VC_NUM + lvl_vc);
        w_next_ptr  = VC_W'((lvl_vc + 1) % VC_NUM);
      end
    end
    w_pick_onehot = {{(Q-1){1'b0}}, 1'b1} << w_pick_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      o_grant       <= '0;
      o_selected_vc <= '0;
      o_busy        <= 1'b0;
      o_credit_err  <= 1'b0;
      o_proto_err   <= 1'b0;
      for (int p = 0; p < PRIO_NUM; p++)
        r_rr_ptr[p] <= '0;
      for (int q = 0; q < Q; q++)
        o_credit_cnt[q*CREDIT_W +: CREDIT_W] <= CREDIT_W'(INIT_CREDITS);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hdr_hs || w_ftr_hs)
            o_proto_err <= 1'b1;
          if (w_any_elig) begin
            o_grant               <= w_pick_onehot;
            o_selected_vc         <= w_pick_q;
            o_busy                <= 1'b1;
            r_rr_ptr[w_pick_prio] <= w_next_ptr;
            r_state               <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_hdr_hs) begin
            if (w_ftr_hs) begin
              o_grant <= '0;
              o_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_BODY;
            end
          end else if (w_ftr_hs) begin
            o_proto_err <= 1'b1;
          end
        end
        S_BODY: begin
          if (w_hdr_hs)
            o_proto_err <= 1'b1;
          if (w_ftr_hs) begin
            o_grant <= '0;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A return and a consume on the same queue cancel out.
      for (int q = 0; q < Q; q++) begin
        if (w_dec[q] && !i_credit_return[q]) begin
          o_credit_cnt[q*CREDIT_W +: CREDIT_W] <=
            o_credit_cnt[q*CREDIT_W +: CREDIT_W] - CREDIT_W'(1);
        end else if (!w_dec[q] && i_credit_return[q]) begin
          if (o_credit_cnt[q*CREDIT_W +: CREDIT_W] == CREDIT_W'(INIT_CREDITS))
            o_credit_err <= 1'b1;
          else
            o_credit_cnt[q*CREDIT_W +: CREDIT_W] <=
              o_credit_cnt[q*CREDIT_W +: CREDIT_W] + CREDIT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exa_vc_credit_scheduler.sv
// ============================================================================
// tb_exa_vc_credit_scheduler: directed-vector bench for the VC credit
// scheduler with hand-computed expectations.          Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exa_vc_credit_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i_req;
  logic [3:0]  i_credit_return;
  logic        i_header_valid;
  logic        i_header_ready;
  logic        i_footer_valid;
  logic        i_footer_ready;
  logic [3:0]  o_grant;
  logic [1:0]  o_selected_vc;
  logic        o_busy;
  logic [15:0] o_credit_cnt;
  logic        o_credit_err;
  logic        o_proto_err;

  int n_vec = 0;
  int n_err = 0;

  exa_vc_credit_scheduler #(
    .PRIO_NUM(2), .VC_NUM(2), .CREDIT_W(4), .INIT_CREDITS(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_credit_return(i_credit_return),
    .i_header_valid(i_header_valid), .i_header_ready(i_header_ready),
    .i_footer_valid(i_footer_valid), .i_footer_ready(i_footer_ready),
    .o_grant(o_grant), .o_selected_vc(o_selected_vc), .o_busy(o_busy),
    .o_credit_cnt(o_credit_cnt), .o_credit_err(o_credit_err),
    .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cred(input int q);
    return o_credit_cnt[q*4 +: 4];
  endfunction

  task automatic hdr(input logic v);
    i_header_valid = v;
    i_header_ready = v;
  endtask

  task automatic ftr(input logic v);
    i_footer_valid = v;
    i_footer_ready = v;
  endtask

  // From IDLE with i_req driven: arbitrate, header handshake, footer handshake.
  task automatic packet(input int exp_q, input string tag);
    logic [3:0] exp_g;
    exp_g = 4'b0001 << exp_q;
    step();
    chk({tag, "_grant"}, o_grant, exp_g);
    chk({tag, "_sel"}, o_selected_vc, exp_q);
    chk({tag, "_busy"}, o_busy, 1);
    hdr(1); step(); hdr(0);
    ftr(1); step(); ftr(0);
    chk({tag, "_idle"}, o_grant, 0);
  endtask

  // Grants packets on the requested queue until no grant appears (bounded).
  task automatic run_pkts(input logic [3:0] exp_g, input int max_pkts, output int n);
    n = 0;
    for (int i = 0; i < max_pkts; i++) begin
      step();
      if (o_grant == 4'b0000) break;
      chk("run_grant", o_grant, exp_g);
      n++;
      hdr(1); step(); hdr(0);
      ftr(1); step(); ftr(0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    i_req = '0;
    i_credit_return = '0;
    hdr(0);
    ftr(0);
    step(); step();
    chk("rst_grant", o_grant, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_sel", o_selected_vc, 0);
    chk("rst_cred", o_credit_cnt, 16'h8888);
    chk("rst_errs", {o_credit_err, o_proto_err}, 0);
    rst = 1'b0;

    // Round-robin inside priority 0
    i_req = 4'b0011;
    packet(0, "rr0");
    packet(1, "rr1");
    packet(0, "rr2");
    chk("rr_cred", o_credit_cnt, 16'h8876);

    // Priority 1 beats priority 0
    i_req = 4'b0101;
    packet(2, "prio_q2");
    chk("prio_cred", o_credit_cnt, 16'h8776);

    i_req = 4'b1111;
    packet(3, "sp0");
    packet(2, "sp1");
    packet(3, "sp2");
    chk("sp_cred", o_credit_cnt, 16'h6676);

    // Return and consume on q2 in the same cycle
    i_req = 4'b0100;
    packet(2, "q2_pre");
    chk("q2_five", cred(2), 5);
    step();
    chk("simul_grant", o_grant, 4'b0100);
    hdr(1); i_credit_return = 4'b0100;
    step();
    hdr(0); i_credit_return = 4'b0000;
    chk("simul_cred", cred(2), 5);
    ftr(1); step(); ftr(0);

    // Saturating return on q1
    i_req = 4'b0000;
    i_credit_return = 4'b0010; step(); i_credit_return = 4'b0000;
    chk("q1_full", cred(1), 8);
    chk("cerr_clear", o_credit_err, 0);
    i_credit_return = 4'b0010; step(); i_credit_return = 4'b0000;
    chk("q1_sat", cred(1), 8);
    chk("cerr_set", o_credit_err, 1);
    step();
    chk("cerr_sticky", o_credit_err, 1);

    // Credit starvation on q3 (6 credits left)
    i_req = 4'b1000;
    run_pkts(4'b1000, 12, n);
    chk("starve_cnt", n, 6);
    chk("starve_cred", cred(3), 0);
    step();
    chk("starve_idle", o_grant, 0);
    i_credit_return = 4'b1000; step(); i_credit_return = 4'b0000;
    chk("ret_no_grant_yet", o_grant, 0);
    step();
    chk("ret_grant", o_grant, 4'b1000);
    hdr(1); step(); hdr(0);
    ftr(1); step(); ftr(0);
    step(); step();
    chk("ret_only_one", o_grant, 0);
    chk("ret_cred", cred(3), 0);
    chk("perr_clear", o_proto_err, 0);

    // Single-flit packet on q0
    i_req = 4'b0001;
    step();
    chk("sf_grant", o_grant, 4'b0001);
    hdr(1); ftr(1); step(); hdr(0); ftr(0);
    chk("sf_idle_grant", o_grant, 0);
    chk("sf_idle_busy", o_busy, 0);
    chk("sf_cred", cred(0), 5);
    chk("sf_perr", o_proto_err, 0);
    step();
    chk("sf_regrant", o_grant, 4'b0001);
    hdr(1); step(); hdr(0);
    ftr(1); step(); ftr(0);
    chk("sf_cred2", cred(0), 4);

    // Footer handshake while idle
    i_req = 4'b0000;
    ftr(1); step(); ftr(0);
    chk("perr_set", o_proto_err, 1);
    chk("perr_busy", o_busy, 0);

    // Leave prio-1 pointer at vc1, then reset in BODY with credit[1]=3
    i_req = 4'b0100;
    packet(2, "pre_rst_q2");
    i_req = 4'b0010;
    run_pkts(4'b0010, 4, n);
    chk("q1_pkts", n, 4);
    step();
    chk("body_grant", o_grant, 4'b0010);
    hdr(1); step(); hdr(0);
    chk("body_cred", cred(1), 3);
    chk("body_busy", o_busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_grant", o_grant, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_cred", o_credit_cnt, 16'h8888);
    chk("mid_rst_errs", {o_credit_err, o_proto_err}, 0);
    i_req = 4'b1100;
    packet(2, "ptr_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1);
  end

endmodule

`default_nettype wire
